// File: rtl/fetcher.sv
// Stage-1 instruction fetch: owns the PC, issues single-outstanding word reads and
// buffers returned instructions for the decoder; redirects flush buffer and in-flight fetches.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif

module fetcher #(
  parameter logic [`WORD_SIZE-1:0] RESET_ADDRESS = 32'h0000_0000,
  parameter int                    BUFFER_DEPTH  = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  output logic                    o_mem_req_valid,
  output logic [`WORD_SIZE-1:0]   o_mem_req_address,
  input  logic                    i_mem_req_ready,
  input  logic                    i_mem_resp_valid,
  input  logic [`INSTR_SIZE-1:0]  i_mem_resp_data,
  input  logic                    i_redirect_valid,
  input  logic [`WORD_SIZE-1:0]   i_redirect_address,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [`INSTR_SIZE-1:0]  o_instruction,
  output logic [`WORD_SIZE-1:0]   o_instruction_address
);

  localparam int PW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int CW = $clog2(BUFFER_DEPTH + 1);
  localparam logic [`WORD_SIZE-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                   state_r, state_next_s;
  logic [`WORD_SIZE-1:0]    pc_r, pc_next_s, req_addr_r;
  logic [`INSTR_SIZE-1:0]   data_r [BUFFER_DEPTH];
  logic [`WORD_SIZE-1:0]    addr_r [BUFFER_DEPTH];
  logic [PW-1:0]            rd_ptr_r, wr_ptr_r;
  logic [CW-1:0]            count_r;
  logic                     req_valid_s, req_fire_s, push_s, pop_s, space_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(BUFFER_DEPTH - 1)) begin
      ptr_inc = {PW{1'b0}};
    end else begin
      ptr_inc = p + PW'(1);
    end
  endfunction

  assign space_s = (count_r < CW'(BUFFER_DEPTH));
  assign pop_s   = (count_r != {CW{1'b0}}) && i_ready && !i_redirect_valid;

  // Next-state, PC update and request generation
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    req_valid_s  = 1'b0;
    req_fire_s   = 1'b0;
    push_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Held low while reset is asserted so the request drops immediately.
        req_valid_s = i_rst_n && space_s && !i_redirect_valid;
        if (req_valid_s && i_mem_req_ready) begin
          req_fire_s   = 1'b1;
          state_next_s = ST_WAIT;
          pc_next_s    = pc_r + 32'd4;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (i_mem_resp_valid) begin
          push_s       = !i_redirect_valid;
          state_next_s = ST_IDLE;
        end else if (i_redirect_valid) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (i_mem_resp_valid) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
    if (i_redirect_valid) begin
      pc_next_s = i_redirect_address & ALIGN_MASK;
    end else begin
      pc_next_s = pc_next_s;
    end
  end

  // FSM state, PC and in-flight request address
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= ST_IDLE;
      pc_r       <= RESET_ADDRESS & ALIGN_MASK;
      req_addr_r <= 32'h0000_0000;
    end else begin
      state_r <= state_next_s;
      pc_r    <= pc_next_s;
      if (req_fire_s) begin
        req_addr_r <= pc_r;
      end
    end
  end

  // Instruction buffer: circular FIFO cleared by redirect
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        data_r[i] <= {`INSTR_SIZE{1'b0}};
        addr_r[i] <= {`WORD_SIZE{1'b0}};
      end
    end else if (i_redirect_valid) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        data_r[wr_ptr_r] <= i_mem_resp_data;
        addr_r[wr_ptr_r] <= req_addr_r;
        wr_ptr_r         <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign o_mem_req_valid       = req_valid_s;
  assign o_mem_req_address     = pc_r;
  assign o_valid               = (count_r != {CW{1'b0}});
  assign o_instruction         = data_r[rd_ptr_r];
  assign o_instruction_address = addr_r[rd_ptr_r];

endmodule

// File: tb/tb_fetcher.sv
// Directed bench for fetcher: a cycle table for in-order fetch (plus a wrap-around PC
// instance), then hand-written sequences for back-pressure, redirects and mid-run reset.
`timescale 1ns/1ps
module tb_fetcher;

  logic        clk, rst_n;
  logic        mem_ready, resp_valid, redirect_valid, dec_ready;
  logic [31:0] resp_data, redirect_address;
  logic        req_valid, ov, req_valid2, ov2;
  logic [31:0] req_addr, oi, oia, req_addr2, oi2, oia2;
  int          total, bad;

  fetcher #(.RESET_ADDRESS(32'h0000_0000), .BUFFER_DEPTH(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_mem_req_valid(req_valid), .o_mem_req_address(req_addr), .i_mem_req_ready(mem_ready),
    .i_mem_resp_valid(resp_valid), .i_mem_resp_data(resp_data),
    .i_redirect_valid(redirect_valid), .i_redirect_address(redirect_address),
    .o_valid(ov), .i_ready(dec_ready), .o_instruction(oi), .o_instruction_address(oia)
  );

  // Same stimulus, PC starting near the top of the address space
  fetcher #(.RESET_ADDRESS(32'hFFFF_FFF8), .BUFFER_DEPTH(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_mem_req_valid(req_valid2), .o_mem_req_address(req_addr2), .i_mem_req_ready(mem_ready),
    .i_mem_resp_valid(resp_valid), .i_mem_resp_data(resp_data),
    .i_redirect_valid(redirect_valid), .i_redirect_address(redirect_address),
    .o_valid(ov2), .i_ready(dec_ready), .o_instruction(oi2), .o_instruction_address(oia2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        ir;
    logic        ev;
    logic [31:0] ea;
    logic        eo;
    logic [31:0] ei;
    logic [31:0] eia;
    logic [31:0] ea2;
    logic [31:0] eia2;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rd,
                     input logic redir, input logic [31:0] ra, input logic ir);
    @(negedge clk);
    mem_ready        = rdy;
    resp_valid       = rv;
    resp_data        = rd;
    redirect_valid   = redir;
    redirect_address = ra;
    dec_ready        = ir;
    #1;
  endtask

  task automatic expo(input string nm, input logic ev, input logic [31:0] ea,
                      input logic eo, input logic [31:0] ei, input logic [31:0] eia);
    chk({nm, ".req_valid"}, {31'd0, req_valid}, {31'd0, ev});
    if (ev) chk({nm, ".req_addr"}, req_addr, ea);
    chk({nm, ".o_valid"}, {31'd0, ov}, {31'd0, eo});
    if (eo) begin
      chk({nm, ".instr"}, oi, ei);
      chk({nm, ".iaddr"}, oia, eia);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; mem_ready = 1'b0; resp_valid = 1'b0; resp_data = 32'h0;
    redirect_valid = 1'b0; redirect_address = 32'h0; dec_ready = 1'b0;

    // Fetch order and data/address pairing; dut2 shows the PC wrapping past 0xFFFFFFFC
    tbl[0] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0, 1'b0, 32'h0,         32'h0, 32'hFFFF_FFF8, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0, 32'h0,         32'h0};
    tbl[2] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF8};
    tbl[3] = '{1'b1, 1'b1, 32'hFFFF_FFFB, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0, 32'h0,         32'h0};
    tbl[4] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8, 1'b1, 32'hFFFF_FFFB, 32'h4, 32'h0,         32'hFFFF_FFFC};
    tbl[5] = '{1'b1, 1'b1, 32'hFFFF_FFF7, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0, 32'h0,         32'h0};
    tbl[6] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hC, 1'b1, 32'hFFFF_FFF7, 32'h8, 32'h4,         32'h0};

    repeat (2) @(negedge clk);
    #1;
    chk("rst.req_valid", {31'd0, req_valid}, 32'd0);
    chk("rst.o_valid", {31'd0, ov}, 32'd0);
    chk("rst.instr", oi, 32'h0);
    chk("rst.iaddr", oia, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].rdy, tbl[i].rv, tbl[i].rdata, 1'b0, 32'h0, tbl[i].ir);
      expo($sformatf("t1.row%0d", i), tbl[i].ev, tbl[i].ea, tbl[i].eo, tbl[i].ei, tbl[i].eia);
      if (tbl[i].ev) chk($sformatf("t5.row%0d.req_addr", i), req_addr2, tbl[i].ea2);
      if (tbl[i].eo) chk($sformatf("t5.row%0d.iaddr", i), oia2, tbl[i].eia2);
    end

    // Back-pressure: buffer fills to two entries and requests stop
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);          expo("t2.a", 1'b1, 32'hC, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b1, 32'hFFFF_FFF3, 1'b0, 32'h0, 1'b0);  expo("t2.b", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);          expo("t2.c", 1'b1, 32'h10, 1'b1, 32'hFFFF_FFF3, 32'hC);
    cyc(1'b1, 1'b1, 32'hFFFF_FFEF, 1'b0, 32'h0, 1'b0);  expo("t2.d", 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF3, 32'hC);
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      expo($sformatf("t2.hold%0d", k), 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF3, 32'hC);
    end
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);          expo("t2.pop0", 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF3, 32'hC);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);          expo("t2.pop1", 1'b1, 32'h14, 1'b1, 32'hFFFF_FFEF, 32'h10);
    cyc(1'b1, 1'b1, 32'hFFFF_FFEB, 1'b0, 32'h0, 1'b0);  expo("t2.e", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Redirect while waiting: stale response drained, fetch resumes at aligned target
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);          expo("t3.a", 1'b1, 32'h18, 1'b1, 32'hFFFF_FFEB, 32'h14);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);          expo("t3.b", 1'b1, 32'h18, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h103, 1'b0);        expo("t3.redir", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);          expo("t3.drain", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b1, 32'hFFFF_FFE7, 1'b0, 32'h0, 1'b0);  expo("t3.stale", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);          expo("t3.resume", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0);

    // Redirect together with response and pop: nothing buffered, nothing popped
    cyc(1'b1, 1'b1, 32'hFFFF_FEFF, 1'b0, 32'h0, 1'b0);  expo("t4.a", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);          expo("t4.b", 1'b1, 32'h104, 1'b1, 32'hFFFF_FEFF, 32'h100);
    cyc(1'b1, 1'b1, 32'hFFFF_FEFB, 1'b1, 32'h200, 1'b1); expo("t4.redir", 1'b0, 32'h0, 1'b1, 32'hFFFF_FEFF, 32'h100);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);          expo("t4.after", 1'b1, 32'h200, 1'b0, 32'h0, 32'h0);

    // Redirect in IDLE suppresses the request; repeated redirects in DRAIN
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0);        expo("t4.idle_redir", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);          expo("t4.c", 1'b1, 32'h300, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h400, 1'b0);        expo("t4.d", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h504, 1'b0);        expo("t4.e", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);          expo("t4.f", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b0);  expo("t4.g", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);          expo("t4.h", 1'b1, 32'h504, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);  expo("t4.idle_resp", 1'b1, 32'h504, 1'b0, 32'h0, 32'h0);

    // Reset while a fetch is outstanding and the buffer holds an entry
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);          expo("t6.a", 1'b1, 32'h504, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b1, 32'hFFFF_FAFB, 1'b0, 32'h0, 1'b0);  expo("t6.b", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);          expo("t6.c", 1'b1, 32'h508, 1'b1, 32'hFFFF_FAFB, 32'h504);
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b0; resp_valid = 1'b0;
    #1;
    chk("t6.rst.req_valid", {31'd0, req_valid}, 32'd0);
    chk("t6.rst.o_valid", {31'd0, ov}, 32'd0);
    chk("t6.rst.req_valid2", {31'd0, req_valid2}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; resp_valid = 1'b1; resp_data = 32'hDEAD_BEEF;
    #1;
    expo("t6.late", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("t6.late.req_addr2", req_addr2, 32'hFFFF_FFF8);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);          expo("t6.d", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);  expo("t6.e", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);          expo("t6.f", 1'b1, 32'h4, 1'b1, 32'hFFFF_FFFF, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
